filtro_match_x: RTL and testbench

Sequential post-processor for the 4-bit constant comparator's match output `Q`: it sits directly downstream of the comparator. It qualifies `Q` with a sample-valid strobe and confirms a match only after `N_CONSEC` consecutive valid matching samples. It counts confirmed match events in a saturating counter and raises an event flag that is held until acknowledged.

---
 rtl/filtro_match_x.sv | 118 +++++++++++
 tb/tb_filtro_match_x.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/filtro_match_x.sv
// filtro_match_x: qualifies the comparator match output Q with a sample-valid
// strobe, confirms a match after N_CONSEC consecutive valid matches, counts
// confirmed events in a saturating counter and holds an event flag until ack.
module filtro_match_x #(
   parameter int unsigned N_CONSEC = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Q,
   input  logic             v,
   input  logic             clr,
   input  logic             ack,
   output logic             det,
   output logic             evt,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   localparam int unsigned RUN_W = 4;
   localparam logic [RUN_W:0]   N_TGT   = (RUN_W+1)'(N_CONSEC);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      DET  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] run;
   logic [RUN_W-1:0] run_nxt;
   logic             confirm_c;

   // State and run-length register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         run   <= '0;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
      end
   end

   // Next-state and confirmation decode; invalid samples freeze everything
   always_comb begin
      state_nxt = state;
      run_nxt   = run;
      confirm_c = 1'b0;
      if (v) begin
         case (state)
            IDLE: begin
               if (Q) begin
                  if (N_TGT == (RUN_W+1)'(1)) begin
                     state_nxt = DET;
                     confirm_c = 1'b1;
                  end else begin
                     state_nxt = ARM;
                     run_nxt   = RUN_W'(1);
                  end
               end
            end
            ARM: begin
               if (Q) begin
                  if (((RUN_W+1)'(run) + (RUN_W+1)'(1)) == N_TGT) begin
                     state_nxt = DET;
                     run_nxt   = '0;
                     confirm_c = 1'b1;
                  end else begin
                     run_nxt = run + RUN_W'(1);
                  end
               end else begin
                  state_nxt = IDLE;
                  run_nxt   = '0;
               end
            end
            DET: begin
               if (!Q) state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
               run_nxt   = '0;
            end
         endcase
      end
   end

   // Registered detect level mirrors the state being entered
   always_ff @(posedge clk) begin
      if (rst) det <= 1'b0;
      else     det <= (state_nxt == DET);
   end

   // Event flag: a new confirmation wins over a coincident acknowledge
   always_ff @(posedge clk) begin
      if (rst)            evt <= 1'b0;
      else if (confirm_c) evt <= 1'b1;
      else if (ack)       evt <= 1'b0;
   end

   // Saturating event counter with sticky overflow; clear still counts a coincident event
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         cnt <= confirm_c ? CNT_ONE : '0;
         ovf <= 1'b0;
      end else if (confirm_c) begin
         if (cnt == CNT_MAX) ovf <= 1'b1;
         else                cnt <= cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_filtro_match_x.sv
// tb_filtro_match_x: random and directed stimulus on two instances (8-bit and
// 2-bit counters) checked each cycle against a streak-count reference model.
module tb_filtro_match_x;

   localparam int unsigned N = 3;

   logic       clk = 1'b0;
   logic       rst, q, v, clr, ack;
   logic       det_a, evt_a, ovf_a;
   logic [7:0] cnt_a;
   logic       det_b, evt_b, ovf_b;
   logic [1:0] cnt_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // reference model state
   int streak = 0;
   bit m_det = 0, m_evt = 0, m_ovf_a = 0, m_ovf_b = 0;
   int m_cnt_a = 0, m_cnt_b = 0;

   always #5 clk = ~clk;

   filtro_match_x #(.N_CONSEC(N), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .Q(q), .v(v), .clr(clr), .ack(ack),
      .det(det_a), .evt(evt_a), .cnt(cnt_a), .ovf(ovf_a));

   filtro_match_x #(.N_CONSEC(N), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .Q(q), .v(v), .clr(clr), .ack(ack),
      .det(det_b), .evt(evt_b), .cnt(cnt_b), .ovf(ovf_b));

   task automatic cmp(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cnt_model(inout int c, inout bit o, input int maxv,
                            input bit conf, input bit cl);
      if (cl) begin
         c = conf ? 1 : 0;
         o = 0;
      end else if (conf) begin
         if (c == maxv) o = 1;
         else           c = c + 1;
      end
   endtask

   // model: det means the current run of consecutive valid matches reached N
   task automatic model_update(input bit vv, qq, aa, cc, rr);
      bit conf;
      conf = 0;
      if (rr) begin
         streak = 0; m_det = 0; m_evt = 0;
         m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
      end else begin
         if (vv) begin
            if (qq) begin
               if (streak < int'(N)) begin
                  streak = streak + 1;
                  if (streak == int'(N)) conf = 1;
               end
            end else begin
               streak = 0;
            end
         end
         m_det = (streak >= int'(N));
         if (conf)    m_evt = 1;
         else if (aa) m_evt = 0;
         cnt_model(m_cnt_a, m_ovf_a, 255, conf, cc);
         cnt_model(m_cnt_b, m_ovf_b, 3, conf, cc);
      end
   endtask

   task automatic step(input bit vv, qq, aa = 0, cc = 0, rr = 0);
      @(negedge clk);
      v = vv; q = qq; ack = aa; clr = cc; rst = rr;
      @(posedge clk);
      model_update(vv, qq, aa, cc, rr);
      #1;
   endtask

   task automatic confirm3();
      step(1, 1); step(1, 1); step(1, 1);
   endtask

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("det_a", int'(det_a), int'(m_det));
         cmp("evt_a", int'(evt_a), int'(m_evt));
         cmp("cnt_a", int'(cnt_a), m_cnt_a);
         cmp("ovf_a", int'(ovf_a), int'(m_ovf_a));
         cmp("det_b", int'(det_b), int'(m_det));
         cmp("evt_b", int'(evt_b), int'(m_evt));
         cmp("cnt_b", int'(cnt_b), m_cnt_b);
         cmp("ovf_b", int'(ovf_b), int'(m_ovf_b));
      end
   end

   initial begin
      rst = 1; q = 0; v = 0; clr = 0; ack = 0;
      step(0, 0, 0, 0, 1);
      chk_en = 1;
      cmp("rst_det", int'(det_a), 0);
      cmp("rst_evt", int'(evt_a), 0);
      cmp("rst_cnt", int'(cnt_a), 0);
      cmp("rst_ovf", int'(ovf_a), 0);

      // three consecutive matches
      step(1, 1); cmp("t1_det_e1", int'(det_a), 0);
      step(1, 1); cmp("t1_det_e2", int'(det_a), 0);
      step(1, 1);
      cmp("t1_det_e3", int'(det_a), 1);
      cmp("t1_evt_e3", int'(evt_a), 1);
      cmp("t1_cnt_e3", int'(cnt_a), 1);

      // broken run
      step(0, 0, 0, 0, 1);
      step(1, 1); step(1, 1); step(1, 0); step(1, 1); step(1, 1);
      cmp("t2_det_e5", int'(det_a), 0);
      cmp("t2_evt_e5", int'(evt_a), 0);
      step(1, 1);
      cmp("t2_det_e6", int'(det_a), 1);
      cmp("t2_cnt_e6", int'(cnt_a), 1);

      // valid gaps and release
      step(0, 0, 0, 0, 1);
      step(1, 1); step(0, 1); step(1, 1); step(0, 1);
      cmp("t3_det_e4", int'(det_a), 0);
      step(1, 1);
      cmp("t3_det_e5", int'(det_a), 1);
      step(1, 0);
      cmp("t3_det_rel", int'(det_a), 0);
      cmp("t3_cnt_rel", int'(cnt_a), 1);

      // handshake
      step(0, 0, 0, 0, 1);
      confirm3();
      for (int i = 0; i < 5; i++) begin
         step(0, 0);
         cmp("t4_evt_hold", int'(evt_a), 1);
      end
      step(0, 0, 1);
      cmp("t4_evt_ack", int'(evt_a), 0);
      step(1, 0);
      confirm3();
      step(1, 0);
      step(1, 1); step(1, 1);
      step(1, 1, 1);
      cmp("t4_evt_ack_conf", int'(evt_a), 1);
      cmp("t4_cnt_ack_conf", int'(cnt_a), 3);

      // saturation and clear on the 2-bit instance
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         confirm3();
         step(1, 0);
      end
      cmp("t5_cnt_sat", int'(cnt_b), 3);
      cmp("t5_ovf_sat", int'(ovf_b), 1);
      cmp("t5_cnt_wide", int'(cnt_a), 4);
      step(0, 0, 0, 1);
      cmp("t5_cnt_clr", int'(cnt_b), 0);
      cmp("t5_ovf_clr", int'(ovf_b), 0);
      step(1, 1); step(1, 1);
      step(1, 1, 0, 1);
      cmp("t5_cnt_clr_conf", int'(cnt_b), 1);
      cmp("t5_det_clr_conf", int'(det_b), 1);

      // reset mid-run and in DET
      step(0, 0, 0, 0, 1);
      step(1, 1); step(1, 1);
      step(0, 0, 0, 0, 1);
      step(1, 1); step(1, 1);
      cmp("t6_no_early", int'(det_a), 0);
      step(1, 1);
      cmp("t6_fresh_det", int'(det_a), 1);
      step(1, 0);
      confirm3();
      cmp("t6_cnt2", int'(cnt_a), 2);
      step(1, 1, 0, 0, 1);
      cmp("t6_rst_det", int'(det_a), 0);
      cmp("t6_rst_evt", int'(evt_a), 0);
      cmp("t6_rst_cnt", int'(cnt_a), 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 149) == 0));
      end

      @(negedge clk);
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
